// File: rtl/bk_pipe_alu.sv
`default_nettype none
// ============================================================================
// Module : bk_pipe_alu
// Brief  : Valid/ready pipelined ALU with a Brent-Kung parallel-prefix carry net
// Rev    : 1.0
// ============================================================================
module bk_pipe_alu #(
    parameter int WIDTH = 8,
    parameter int PIPE  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] c,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int         LOG      = $clog2(WIDTH);
    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;

    // ------------------------------------------------------------------
    // Stage 1: input register
    // ------------------------------------------------------------------
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_cin;
    logic [2:0]       r_s1_op;
    logic             w_s1_take;
    logic             w_accept;

    assign in_ready = rst_n & (~r_s1_valid | w_s1_take);
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_cin   <= 1'b0;
            r_s1_op    <= 3'b000;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_accept) begin
                r_s1_a   <= a;
                r_s1_b   <= b;
                // Only a plain ADD honours cin; aliased opcodes force it low.
                r_s1_cin <= (op == c_OP_ADD) ? cin : 1'b0;
                r_s1_op  <= op;
            end
        end
    end

    // Stage 1 combinational: operand conditioning and per-bit g/p
    logic             w_s1_sub;
    logic             w_s1_arith;
    logic             w_s1_cin;
    logic [WIDTH-1:0] w_s1_beff;
    logic [WIDTH-1:0] w_s1_g;
    logic [WIDTH-1:0] w_s1_p;
    logic [WIDTH-1:0] w_s1_logic;

    assign w_s1_sub   = (r_s1_op == c_OP_SUB);
    assign w_s1_arith = w_s1_sub | (r_s1_op == c_OP_ADD) | (r_s1_op > c_OP_XOR);
    assign w_s1_beff  = w_s1_sub ? ~r_s1_b : r_s1_b;
    assign w_s1_cin   = w_s1_sub | r_s1_cin;
    assign w_s1_g     = r_s1_a & w_s1_beff;
    assign w_s1_p     = r_s1_a ^ w_s1_beff;

    always_comb begin
        w_s1_logic = '0;
        case (r_s1_op)
            c_OP_AND: w_s1_logic = r_s1_a & r_s1_b;
            c_OP_OR:  w_s1_logic = r_s1_a | r_s1_b;
            c_OP_XOR: w_s1_logic = r_s1_a ^ r_s1_b;
            default:  w_s1_logic = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Up-sweep; carry-in folded into bit 0 so prefix G[i] is carry out of i
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_ug [0:LOG];
    logic [WIDTH-1:0] w_up [0:LOG];

    assign w_ug[0] = {w_s1_g[WIDTH-1:1], w_s1_g[0] | (w_s1_p[0] & w_s1_cin)};
    assign w_up[0] = w_s1_p;

    genvar gl, gi;
    generate
        for (gl = 0; gl < LOG; gl++) begin : g_up_lvl
            for (gi = 0; gi < WIDTH; gi++) begin : g_up_bit
                if ((gi + 1) % (2 ** (gl + 1)) == 0) begin : g_node
                    assign w_ug[gl+1][gi] = w_ug[gl][gi] | (w_up[gl][gi] & w_ug[gl][gi - 2 ** gl]);
                    assign w_up[gl+1][gi] = w_up[gl][gi] & w_up[gl][gi - 2 ** gl];
                end else begin : g_pass
                    assign w_ug[gl+1][gi] = w_ug[gl][gi];
                    assign w_up[gl+1][gi] = w_up[gl][gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 2 (registered for PIPE=3, merged into the output stage otherwise)
    // ------------------------------------------------------------------
    logic             w_mid_valid;
    logic [WIDTH-1:0] w_mid_g;
    logic [WIDTH-1:0] w_mid_pu;
    logic [WIDTH-1:0] w_mid_p;
    logic [WIDTH-1:0] w_mid_logic;
    logic             w_mid_cin;
    logic             w_mid_arith;
    logic             w_out_load;

    generate
        if (PIPE == 3) begin : g_s2_reg
            logic             r_s2_valid;
            logic [WIDTH-1:0] r_s2_g;
            logic [WIDTH-1:0] r_s2_pu;
            logic [WIDTH-1:0] r_s2_p;
            logic [WIDTH-1:0] r_s2_logic;
            logic             r_s2_cin;
            logic             r_s2_arith;
            logic             w_s2_load;

            assign w_s2_load = ~r_s2_valid | w_out_load;
            assign w_s1_take = w_s2_load;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_s2_valid <= 1'b0;
                    r_s2_g     <= '0;
                    r_s2_pu    <= '0;
                    r_s2_p     <= '0;
                    r_s2_logic <= '0;
                    r_s2_cin   <= 1'b0;
                    r_s2_arith <= 1'b0;
                end else begin
                    if (w_s2_load) begin
                        r_s2_valid <= r_s1_valid;
                    end
                    if (w_s2_load && r_s1_valid) begin
                        r_s2_g     <= w_ug[LOG];
                        r_s2_pu    <= w_up[LOG];
                        r_s2_p     <= w_s1_p;
                        r_s2_logic <= w_s1_logic;
                        r_s2_cin   <= w_s1_cin;
                        r_s2_arith <= w_s1_arith;
                    end
                end
            end

            assign w_mid_valid = r_s2_valid;
            assign w_mid_g     = r_s2_g;
            assign w_mid_pu    = r_s2_pu;
            assign w_mid_p     = r_s2_p;
            assign w_mid_logic = r_s2_logic;
            assign w_mid_cin   = r_s2_cin;
            assign w_mid_arith = r_s2_arith;
        end else begin : g_s2_bypass
            assign w_s1_take   = w_out_load;
            assign w_mid_valid = r_s1_valid;
            assign w_mid_g     = w_ug[LOG];
            assign w_mid_pu    = w_up[LOG];
            assign w_mid_p     = w_s1_p;
            assign w_mid_logic = w_s1_logic;
            assign w_mid_cin   = w_s1_cin;
            assign w_mid_arith = w_s1_arith;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Down-sweep fills in the prefixes the up-sweep left partial
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_dg [0:LOG-1];

    assign w_dg[0] = w_mid_g;

    generate
        for (gl = 1; gl < LOG; gl++) begin : g_dn_lvl
            localparam int c_DIST = 2 ** (LOG - 1 - gl);
            for (gi = 0; gi < WIDTH; gi++) begin : g_dn_bit
                if (((gi + 1) % (2 * c_DIST) == c_DIST) && (gi + 1 > 2 * c_DIST)) begin : g_node
                    assign w_dg[gl][gi] = w_dg[gl-1][gi] | (w_mid_pu[gi] & w_dg[gl-1][gi - c_DIST]);
                end else begin : g_pass
                    assign w_dg[gl][gi] = w_dg[gl-1][gi];
                end
            end
        end
    endgenerate

    // Only a subset of group-propagate bits is consumed by the down-sweep.
    logic w_unused;
    assign w_unused = ^w_mid_pu;

    logic [WIDTH-1:0] w_fin_c;
    logic [WIDTH-1:0] w_fin_sum;
    logic             w_fin_ovf;

    assign w_fin_c   = w_mid_arith ? w_dg[LOG-1] : '0;
    assign w_fin_sum = w_mid_arith ? (w_mid_p ^ {w_fin_c[WIDTH-2:0], w_mid_cin}) : w_mid_logic;
    assign w_fin_ovf = w_mid_arith & (w_fin_c[WIDTH-1] ^ w_fin_c[WIDTH-2]);

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_c;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    assign w_out_load = ~r_out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_c         <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
        end else begin
            if (w_out_load) begin
                r_out_valid <= w_mid_valid;
            end
            if (w_out_load && w_mid_valid) begin
                r_sum  <= w_fin_sum;
                r_c    <= w_fin_c;
                r_cout <= w_fin_c[WIDTH-1];
                r_ovf  <= w_fin_ovf;
                r_zero <= (w_fin_sum == '0);
                r_neg  <= w_fin_sum[WIDTH-1];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign c         = r_c;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign neg       = r_neg;

endmodule
`default_nettype wire

// File: tb/tb_bk_pipe_alu.sv
`default_nettype none
// ============================================================================
// Module : tb_bk_pipe_alu
// Brief  : Directed, table-driven self-checking bench for bk_pipe_alu (8-bit, 3 stages)
// Rev    : 1.0
// ============================================================================
module tb_bk_pipe_alu;

    localparam int WIDTH = 8;
    localparam int PIPE  = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] c;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    always #5 clk = ~clk;

    bk_pipe_alu #(.WIDTH(WIDTH), .PIPE(PIPE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c         (c),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // {sum, c, cout, ovf, zero, neg}
    function automatic logic [19:0] outs();
        return {sum, c, cout, ovf, zero, neg};
    endfunction

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic [7:0] c;
        logic       cout;
        logic       ovf;
        logic       zero;
        logic       neg;
    } vec_t;

    vec_t vecs [15];

    logic [7:0] sa   [8] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd3};
    logic [7:0] sb   [8] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd5};
    logic [7:0] sexp [8] = '{8'd0, 8'd1, 8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd8};

    logic [8:0] expq [$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int fired;

        //              op      a      b    cin  sum    c    cout ovf zero neg
        vecs[0]  = '{3'b000, 8'h03, 8'h05, 1'b0, 8'h08, 8'h07, 0, 0, 0, 0};
        vecs[1]  = '{3'b000, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h7F, 0, 1, 0, 1};
        vecs[2]  = '{3'b000, 8'hFF, 8'h01, 1'b0, 8'h00, 8'hFF, 1, 0, 1, 0};
        vecs[3]  = '{3'b001, 8'h10, 8'h20, 1'b0, 8'hF0, 8'h1F, 0, 0, 0, 1};
        vecs[4]  = '{3'b100, 8'hAA, 8'hFF, 1'b0, 8'h55, 8'h00, 0, 0, 0, 0};
        vecs[5]  = '{3'b000, 8'h0F, 8'h00, 1'b1, 8'h10, 8'h0F, 0, 0, 0, 0};
        vecs[6]  = '{3'b001, 8'h20, 8'h10, 1'b0, 8'h10, 8'hEF, 1, 0, 0, 0};
        vecs[7]  = '{3'b001, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h80, 1, 1, 0, 0};
        vecs[8]  = '{3'b010, 8'hF0, 8'h3C, 1'b1, 8'h30, 8'h00, 0, 0, 0, 0};
        vecs[9]  = '{3'b011, 8'h80, 8'h01, 1'b0, 8'h81, 8'h00, 0, 0, 0, 1};
        vecs[10] = '{3'b101, 8'h01, 8'h01, 1'b1, 8'h02, 8'h01, 0, 0, 0, 0};
        vecs[11] = '{3'b111, 8'hFF, 8'h00, 1'b1, 8'hFF, 8'h00, 0, 0, 0, 1};
        vecs[12] = '{3'b001, 8'h05, 8'h05, 1'b0, 8'h00, 8'hFF, 1, 0, 1, 0};
        vecs[13] = '{3'b010, 8'h0F, 8'hF0, 1'b0, 8'h00, 8'h00, 0, 0, 1, 0};
        vecs[14] = '{3'b000, 8'h80, 8'h80, 1'b0, 8'h00, 8'h80, 1, 1, 1, 0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        op        = 3'b000;
        out_ready = 1'b1;

        // Reset state
        repeat (3) tick;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_outputs", {12'd0, outs()}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Isolated vectors: accept at edge 1, result visible after edge 3
        for (int i = 0; i < 15; i++) begin
            op       = vecs[i].op;
            a        = vecs[i].a;
            b        = vecs[i].b;
            cin      = vecs[i].cin;
            in_valid = 1'b1;
            #1;
            check("vec_in_ready", {31'd0, in_ready}, 32'd1);
            tick;
            in_valid = 1'b0;
            tick;
            check("vec_not_early", {31'd0, out_valid}, 32'd0);
            tick;
            check("vec_result", {11'd0, out_valid, outs()},
                  {11'd0, 1'b1, vecs[i].sum, vecs[i].c, vecs[i].cout,
                   vecs[i].ovf, vecs[i].zero, vecs[i].neg});
            tick;
        end

        // Back-to-back stream of eight ADDs
        op  = 3'b000;
        cin = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                a        = sa[i];
                b        = sb[i];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick;
            if (i >= 2 && i < 10)
                check("stream_result", {23'd0, out_valid, sum}, {23'd0, 1'b1, sexp[i-2]});
            else
                check("stream_idle", {31'd0, out_valid}, 32'd0);
        end

        // Backpressure: out_ready low for the first five cycles of a stream
        acc   = 0;
        fired = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = (cyc >= 5);
            if (acc < 6) begin
                a        = 8'(37 * acc + 11);
                b        = 8'(91 * acc + 200);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 3)
                check("bp_accepted", acc, 32'd3);
            if (cyc == 3 || cyc == 4) begin
                check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
                check("bp_hold", {22'd0, out_valid, cout, sum}, {22'd0, 1'b1, 9'd211});
            end
            if (cyc >= 5 && cyc < 11)
                check("bp_no_gap", {31'd0, out_valid}, 32'd1);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL bp_spurious: got result 0x%0h, want no output", sum);
                end else begin
                    check("bp_order", {23'd0, cout, sum}, {23'd0, expq.pop_front()});
                end
                fired++;
            end
            if (in_valid && in_ready) begin
                expq.push_back(9'(a) + 9'(b));
                acc++;
            end
            tick;
        end
        check("bp_count", fired, 32'd6);
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset with two operations in flight
        a        = 8'h21;
        b        = 8'h42;
        in_valid = 1'b1;
        tick;
        a = 8'h05;
        b = 8'h06;
        tick;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        tick;
        check("rst_mid_outputs", {11'd0, out_valid, outs()}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            check("rst_mid_no_stale", {31'd0, out_valid}, 32'd0);
        end

        // Pipeline still usable after the flush
        a        = 8'h12;
        b        = 8'h34;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        check("post_rst_result", {23'd0, out_valid, sum}, {23'd0, 1'b1, 8'h46});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
